// File: rtl/mips_mem_arbiter_if.sv
// mips_mem_arbiter_if: bundle of loader, data, fetch, core-control and memory signals for mips_mem_arbiter
// Parameters: AW word-address width, DW data width.
// master modport: requester/memory side (drives requests, core status, mem_rdata).
// slave modport : arbiter side (drives grants, rvalids, rdata, cpu_hold, mem_* controls).
interface mips_mem_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic          ld_req, ld_we, ld_done, ld_gnt;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic          d_req, d_we, d_gnt, d_rvalid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          i_req, i_gnt, i_rvalid;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] rdata;
    logic          cpu_halted, cpu_hold;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    modport master (
        output ld_req, ld_we, ld_addr, ld_wdata, ld_done,
        output d_req, d_we, d_addr, d_wdata,
        output i_req, i_addr,
        output cpu_halted, mem_rdata,
        input  ld_gnt, d_gnt, d_rvalid, i_gnt, i_rvalid, rdata, cpu_hold,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
    modport slave (
        input  ld_req, ld_we, ld_addr, ld_wdata, ld_done,
        input  d_req, d_we, d_addr, d_wdata,
        input  i_req, i_addr,
        input  cpu_halted, mem_rdata,
        output ld_gnt, d_gnt, d_rvalid, i_gnt, i_rvalid, rdata, cpu_hold,
        output mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: single-port memory arbiter (loader > data > fetch) and BOOT/RUN/HALT core run sequencer
// Ports: clk, rst (async, active-high), bus (mips_mem_arbiter_if.slave: loader, data, fetch,
//        core control and memory signals).
// Optional macro MEM_ARB_STARVE_GUARD_EN: after STARVE_LIM consecutive denied fetch cycles in RUN,
//        fetch outranks data until it is granted.
module mips_mem_arbiter #(
    parameter int AW = 10,
    parameter int DW = 32
`ifdef MEM_ARB_STARVE_GUARD_EN
    , parameter int STARVE_LIM = 4
`endif
) (
    input logic               clk,
    input logic               rst,
    mips_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_e;
    state_e        state_q, state_d;
    logic          core_ok, ld_g, d_g, i_g, fetch_first;
    logic          i_rvalid_q, d_rvalid_q;
    logic [AW-1:0] addr_mux;
    logic [DW-1:0] wdata_mux;
`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIM + 1);
    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    assign fetch_first = starve_cnt_q == SW'(STARVE_LIM);
    // Counts only RUN cycles with a pending, denied fetch; saturates so fetch keeps priority until served.
    always_comb begin
        starve_cnt_d = (state_q == RUN && bus.i_req && !i_g) ?
                       (fetch_first ? starve_cnt_q : starve_cnt_q + 1'b1) : '0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) starve_cnt_q <= '0;
        else     starve_cnt_q <= starve_cnt_d;
    end
`else
    assign fetch_first = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        core_ok = state_q == RUN && !bus.ld_req;
        ld_g    = bus.ld_req;
        d_g     = core_ok && bus.d_req && !(fetch_first && bus.i_req);
        i_g     = core_ok && bus.i_req && (fetch_first || !bus.d_req);
        // Halt wins in RUN; ld_done is only honoured outside RUN.
        state_d = (state_q == RUN) ? (bus.cpu_halted ? HALT : RUN) : (bus.ld_done ? RUN : state_q);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BOOT;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            i_rvalid_q <= i_g;
            d_rvalid_q <= d_g && !bus.d_we;
        end
    end
    assign addr_mux      = ld_g ? bus.ld_addr : d_g ? bus.d_addr : bus.i_addr;
    assign wdata_mux     = ld_g ? bus.ld_wdata : bus.d_wdata;
    assign bus.ld_gnt    = ld_g;
    assign bus.d_gnt     = d_g;
    assign bus.i_gnt     = i_g;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.i_rvalid  = i_rvalid_q;
    assign bus.rdata     = bus.mem_rdata;
    assign bus.cpu_hold  = state_q != RUN;
    assign bus.mem_en    = ld_g || d_g || i_g;
    assign bus.mem_we    = (ld_g && bus.ld_we) || (d_g && bus.d_we);
    assign bus.mem_addr  = addr_mux;
    assign bus.mem_wdata = wdata_mux;
endmodule
